// File: rtl/swchaddr_pkg.sv
// Shared definitions for the MAC learning/lookup engine: FSM states,
// table entry word layout and the MAC-to-index hash.
package swchaddr_pkg;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    RD_D0,
    RD_D1,
    RD_S0,
    RD_S1,
    WR_S0,
    WR_S1,
    RESP
  } state_t;

  // Entry word1 layout; word0 simply holds mac[31:0]
  localparam int W1_VALID_BIT = 31;
  localparam int W1_PORT_LSB  = 16;
  localparam int W1_MACHI_MSB = 15;

  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  // XOR fold of the 48 MAC bits into w-bit slices; bit i lands on bit (i mod w),
  // which is the same as zero-padding the top slice. Caller keeps the low w bits.
  function automatic logic [47:0] mac_hash(input logic [47:0] mac, input int w);
    logic [47:0] h;
    h = '0;
    for (int i = 0; i < 48; i++) begin
      h = h ^ (((mac >> i) & 48'h1) << (i % w));
    end
    return h;
  endfunction

endpackage

// File: rtl/swchaddr_hash.sv
// Purely combinational MAC hash, one instance per looked-up address.
module swchaddr_hash
  import swchaddr_pkg::*;
#(
  parameter int HASH_W = 8
) (
  input  logic [47:0]       mac,
  output logic [HASH_W-1:0] idx
);

  assign idx = HASH_W'(mac_hash(mac, HASH_W));

endmodule

// File: rtl/swchaddr_engine.sv
// Ethernet switch address engine: per request, looks up the destination MAC
// in a direct-mapped table held in external memory, learns the source MAC
// and ingress port, and returns the egress port or a flood indication.
// Optional statistics counters are built when SWCHADDR_STATS_EN is defined.
module swchaddr_engine
  import swchaddr_pkg::*;
#(
  parameter int          HASH_W   = 8,
  parameter int          PORT_W   = 2,
  parameter logic [31:0] TBL_BASE = 32'h0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [47:0]       req_dmac,
  input  logic [47:0]       req_smac,
  input  logic [PORT_W-1:0] req_port,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [PORT_W-1:0] resp_port,
  output logic              resp_flood,
  output logic [31:0]       f0_waddr,
  output logic [31:0]       f0_wdata,
  output logic              f0_write,
  output logic [31:0]       f0_raddr,
  input  logic [31:0]       f0_rdata
`ifdef SWCHADDR_STATS_EN
  ,
  output logic [31:0]       stat_hit,
  output logic [31:0]       stat_miss,
  output logic [31:0]       stat_learn
`endif
);

  state_t              state;
  state_t              next_state;

  logic                init_armed;
  logic [HASH_W:0]     init_idx;

  logic [47:0]         dmac_q;
  logic [47:0]         smac_q;
  logic [PORT_W-1:0]   port_q;

  logic [HASH_W-1:0]   d_idx;
  logic [HASH_W-1:0]   s_idx;
  logic [31:0]         d_base;
  logic [31:0]         s_base;

  // Words captured during the read phase: dst w0, dst w1, src w0, src w1
  logic [31:0]         rd_word [4];

  logic                d_hit;
  logic [PORT_W-1:0]   d_port;
  logic                is_bcast;
  logic                src_match;
  logic [31:0]         learn_w1;

  logic [PORT_W-1:0]   resp_port_q;
  logic                resp_flood_q;

  swchaddr_hash #(.HASH_W(HASH_W)) u_hash_dst (
    .mac (dmac_q),
    .idx (d_idx)
  );

  swchaddr_hash #(.HASH_W(HASH_W)) u_hash_src (
    .mac (smac_q),
    .idx (s_idx)
  );

  assign d_base = TBL_BASE + 32'({d_idx, 1'b0});
  assign s_base = TBL_BASE + 32'({s_idx, 1'b0});

  // The destination words stay untouched from RD_S0 until the next request,
  // so the lookup result is always taken from the table before any learn.
  assign is_bcast = (dmac_q == MAC_BCAST);
  assign d_hit    = rd_word[1][W1_VALID_BIT] &&
                    ({rd_word[1][W1_MACHI_MSB:0], rd_word[0]} == dmac_q);
  assign d_port   = rd_word[1][W1_PORT_LSB +: PORT_W];

  // Source word1 is examined live in RD_S1 so the learn decision costs no extra cycle
  assign src_match = f0_rdata[W1_VALID_BIT] &&
                     (f0_rdata[W1_PORT_LSB +: PORT_W] == port_q) &&
                     ({f0_rdata[W1_MACHI_MSB:0], rd_word[2]} == smac_q);

  // Builds the word1 image of the entry being learned
  always_comb begin
    learn_w1                           = '0;
    learn_w1[W1_VALID_BIT]             = 1'b1;
    learn_w1[W1_PORT_LSB +: PORT_W]    = port_q;
    learn_w1[W1_MACHI_MSB:0]           = smac_q[47:32];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      INIT:    if (init_armed && (init_idx == '1)) next_state = IDLE;
      IDLE:    if (req_valid) next_state = RD_D0;
      RD_D0:   next_state = RD_D1;
      RD_D1:   next_state = RD_S0;
      RD_S0:   next_state = RD_S1;
      RD_S1:   next_state = src_match ? RESP : WR_S0;
      WR_S0:   next_state = WR_S1;
      WR_S1:   next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = INIT;
    endcase
  end

  // FSM outputs: handshakes and memory port decoded from the current state
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    f0_write   = 1'b0;
    f0_waddr   = '0;
    f0_wdata   = '0;
    f0_raddr   = '0;
    case (state)
      INIT: begin
        if (init_armed) begin
          f0_write = 1'b1;
          f0_waddr = TBL_BASE + 32'(init_idx);
        end
      end
      RD_D0: f0_raddr = d_base;
      RD_D1: f0_raddr = d_base + 32'd1;
      RD_S0: f0_raddr = s_base;
      RD_S1: f0_raddr = s_base + 32'd1;
      WR_S0: begin
        f0_write = 1'b1;
        f0_waddr = s_base;
        f0_wdata = smac_q[31:0];
      end
      WR_S1: begin
        f0_write = 1'b1;
        f0_waddr = s_base + 32'd1;
        f0_wdata = learn_w1;
      end
      default: ;
    endcase
  end

  // Table clearing sweep; the arm flag keeps the write strobe low while in reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_armed <= 1'b0;
      init_idx   <= '0;
    end else if (state == INIT) begin
      init_armed <= 1'b1;
      if (init_armed) begin
        init_idx <= init_idx + 1'b1;
      end
    end
  end

  // Registers the request fields on acceptance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dmac_q <= '0;
      smac_q <= '0;
      port_q <= '0;
    end else if (req_valid && req_ready) begin
      dmac_q <= req_dmac;
      smac_q <= req_smac;
      port_q <= req_port;
    end
  end

  // Captures each table word as it is read
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        rd_word[i] <= '0;
      end
    end else begin
      case (state)
        RD_D0:   rd_word[0] <= f0_rdata;
        RD_D1:   rd_word[1] <= f0_rdata;
        RD_S0:   rd_word[2] <= f0_rdata;
        RD_S1:   rd_word[3] <= f0_rdata;
        default: ;
      endcase
    end
  end

  // Latches the response once and holds it through any back-pressure in RESP
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_port_q  <= '0;
      resp_flood_q <= 1'b0;
    end else if (state == RD_S1) begin
      resp_flood_q <= !d_hit || is_bcast;
      resp_port_q  <= (d_hit && !is_bcast) ? d_port : '0;
    end
  end

  assign resp_port  = resp_port_q;
  assign resp_flood = resp_flood_q;

`ifdef SWCHADDR_STATS_EN
  // Wrapping per-request counters, bumped once as each request enters RESP
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_hit   <= '0;
      stat_miss  <= '0;
      stat_learn <= '0;
    end else if ((next_state == RESP) && (state != RESP)) begin
      if (d_hit) begin
        stat_hit <= stat_hit + 32'd1;
      end else begin
        stat_miss <= stat_miss + 32'd1;
      end
      if (state == WR_S1) begin
        stat_learn <= stat_learn + 32'd1;
      end
    end
  end
`endif

endmodule
